// File: rtl/prio_q_sched.sv
// ---------------------------------------------------------------------------
// prio_q_sched
//
// Round-robin scheduler that shares one min-heap priority queue among
// NUM_REQ simulation cores. Each IDLE cycle it picks the first eligible core
// at or after the round-robin pointer, issues that core's enqueue or dequeue
// to the queue for one cycle, and then idles for ISSUE_GAP cycles so the heap
// can settle. A dequeue returns the pre-dequeue root key to the winning core
// one cycle after the issue.
//
// Optional build macro: PRIO_Q_SCHED_STATS_EN adds statistics outputs
// (enqueue/dequeue/stall counters and a q_count high-water mark).
//
// Ports:
//   CLK         clock, rising edge
//   rst         asynchronous active-high reset
//   req_vld     per-core request pending
//   req_deq     per-core op, 1 = dequeue, 0 = enqueue
//   req_data    per-core enqueue key, core i at [i*DW +: DW]
//   req_ack     one-hot, one-cycle grant pulse
//   rsp_vld     dequeued key valid, one-cycle pulse
//   rsp_id      core receiving rsp_data
//   rsp_data    dequeued minimum key
//   q_enq       queue enqueue strobe
//   q_deq       queue dequeue strobe
//   q_inp_data  key presented to the queue
//   q_out_data  queue root (current minimum)
//   q_count     queue element count
//   full        q_count == 2^HD-1
//   empty       q_count == 0
//   stat_enq    (stats build) saturating count of enqueue issues
//   stat_deq    (stats build) saturating count of dequeue issues
//   stat_stall  (stats build) IDLE cycles with requests but none eligible
//   stat_hwm    (stats build) largest q_count observed
// ---------------------------------------------------------------------------
module prio_q_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 16,
  parameter int HD        = 5,
  parameter int ISSUE_GAP = 2,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  logic [NUM_REQ-1:0]    req_deq,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic                  rsp_vld,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_data,
  output logic                  q_enq,
  output logic                  q_deq,
  output logic [DW-1:0]         q_inp_data,
  input  logic [DW-1:0]         q_out_data,
  input  logic [HD-1:0]         q_count,
  output logic                  full,
  output logic                  empty
`ifdef PRIO_Q_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_enq,
  output logic [31:0]           stat_deq,
  output logic [31:0]           stat_stall,
  output logic [HD-1:0]         stat_hwm
`endif
);

  // Capacity 2^HD-1 is exactly the all-ones count value.
  localparam logic [HD-1:0] CAP      = '1;
  localparam logic [3:0]    GAP_LOAD = 4'(ISSUE_GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_win_id;
  logic               r_win_deq;
  logic [DW-1:0]      r_win_data;
  logic [3:0]         r_gap_cnt;

  logic               r_rsp_vld;
  logic [IDW-1:0]     r_rsp_id;
  logic [DW-1:0]      r_rsp_data;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_any_elig;
  logic [IDW-1:0]     w_pick;
  logic [IDW-1:0]     w_ptr_nxt;

  // -------------------------------------------------------------------------
  // Queue status and per-core eligibility
  // -------------------------------------------------------------------------
  assign full  = (q_count == CAP);
  assign empty = (q_count == '0);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_vld[i] && (req_deq[i] ? !empty : !full);
    end
  end

  // Round-robin pick: scan from the farthest offset down to offset 0 so the
  // closest eligible core at or after r_rr_ptr is the last one written.
  always_comb begin
    w_any_elig = 1'b0;
    w_pick     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_elig[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any_elig = 1'b1;
        w_pick     = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_ptr_nxt = (r_win_id == IDW'(NUM_REQ - 1)) ? '0 : r_win_id + IDW'(1);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and queue/grant strobes. The strobes are decoded from the
  // registered state, so an asynchronous reset drops them immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt = r_state;
    req_ack     = '0;
    q_enq       = 1'b0;
    q_deq       = 1'b0;
    q_inp_data  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_elig) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt       = S_GAP;
        req_ack[r_win_id] = 1'b1;
        q_deq             = r_win_deq;
        q_enq             = !r_win_deq;
        if (!r_win_deq) begin
          q_inp_data = r_win_data;
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Winner capture, round-robin pointer, gap counter and dequeue response
  // -------------------------------------------------------------------------
  // NOTE: the captured request and response registers are reset as well, so
  // a reset mid-operation leaves no stale key or id visible on the outputs.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_win_id   <= '0;
      r_win_deq  <= 1'b0;
      r_win_data <= '0;
      r_gap_cnt  <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any_elig) begin
            r_win_id   <= w_pick;
            r_win_deq  <= req_deq[w_pick];
            r_win_data <= req_data[w_pick*DW +: DW];
          end
        end
        S_ISSUE: begin
          r_rr_ptr  <= w_ptr_nxt;
          r_gap_cnt <= GAP_LOAD;
          // The root is still the pre-dequeue minimum on this edge.
          if (r_win_deq) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_id   <= r_win_id;
            r_rsp_data <= q_out_data;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: begin
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  assign rsp_vld  = r_rsp_vld;
  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;

`ifdef PRIO_Q_SCHED_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating statistics
  // -------------------------------------------------------------------------
  logic [31:0]   r_stat_enq;
  logic [31:0]   r_stat_deq;
  logic [31:0]   r_stat_stall;
  logic [HD-1:0] r_stat_hwm;
  logic          w_stall;

  assign w_stall = (r_state == S_IDLE) && (|req_vld) && !w_any_elig;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_stat_enq   <= '0;
      r_stat_deq   <= '0;
      r_stat_stall <= '0;
      r_stat_hwm   <= '0;
    end else begin
      if (q_enq && (r_stat_enq != '1)) begin
        r_stat_enq <= r_stat_enq + 32'd1;
      end
      if (q_deq && (r_stat_deq != '1)) begin
        r_stat_deq <= r_stat_deq + 32'd1;
      end
      if (w_stall && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
      if (q_count > r_stat_hwm) begin
        r_stat_hwm <= q_count;
      end
    end
  end

  assign stat_enq   = r_stat_enq;
  assign stat_deq   = r_stat_deq;
  assign stat_stall = r_stat_stall;
  assign stat_hwm   = r_stat_hwm;
`endif

endmodule

// File: tb/tb_prio_q_sched.sv
// ---------------------------------------------------------------------------
// tb_prio_q_sched
//
// The bench plays both sides of the scheduler: the cores (per-core request
// FIFOs, popped when the reference model grants) and the priority queue
// itself (an unsorted list of keys; count = size, root = smallest key).
// A transaction-level reference model predicts grants, strobes and
// responses cycle by cycle; directed tasks add their own targeted checks.
// ---------------------------------------------------------------------------
module tb_prio_q_sched;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 16;
  localparam int HD        = 5;
  localparam int ISSUE_GAP = 2;
  localparam int IDW       = 2;
  localparam int CAP       = 31;
  localparam int OPQ       = 64;

  logic                  CLK = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ-1:0]    req_deq;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ack;
  logic                  rsp_vld;
  logic [IDW-1:0]        rsp_id;
  logic [DW-1:0]         rsp_data;
  logic                  q_enq;
  logic                  q_deq;
  logic [DW-1:0]         q_inp_data;
  logic [DW-1:0]         q_out_data;
  logic [HD-1:0]         q_count;
  logic                  full;
  logic                  empty;
`ifdef PRIO_Q_SCHED_STATS_EN
  logic [31:0]           stat_enq;
  logic [31:0]           stat_deq;
  logic [31:0]           stat_stall;
  logic [HD-1:0]         stat_hwm;
`endif

  prio_q_sched #(
    .NUM_REQ  (NUM_REQ),
    .DW       (DW),
    .HD       (HD),
    .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_deq   (req_deq),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .rsp_vld   (rsp_vld),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .q_enq     (q_enq),
    .q_deq     (q_deq),
    .q_inp_data(q_inp_data),
    .q_out_data(q_out_data),
    .q_count   (q_count),
    .full      (full),
    .empty     (empty)
`ifdef PRIO_Q_SCHED_STATS_EN
    ,
    .stat_enq  (stat_enq),
    .stat_deq  (stat_deq),
    .stat_stall(stat_stall),
    .stat_hwm  (stat_hwm)
`endif
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Modelled queue contents
  logic [DW-1:0] heap_q[$];

  // Per-core request FIFOs (the cores)
  logic          op_deq [NUM_REQ][OPQ];
  logic [DW-1:0] op_data[NUM_REQ][OPQ];
  int            op_head[NUM_REQ];
  int            op_tail[NUM_REQ];

  // Reference model state
  bit            m_iss;       // an op is being issued this cycle
  int            m_id;
  bit            m_deq;
  logic [DW-1:0] m_data;
  int            m_cool;      // cycles left before arbitration resumes
  int            m_ptr;
  bit            m_rsp;
  int            m_rsp_id;
  logic [DW-1:0] m_rsp_data;

  bit            rand_mode = 0;
  int            rand_deq_pct = 50;

  // Observed-event logs (from DUT outputs) for directed checks
  int            ack_id_log[$];
  int            ack_cyc_log[$];
  bit            ack_deq_log[$];
  logic [DW-1:0] ack_inp_log[$];
  int            rsp_id_log[$];
  int            rsp_cyc_log[$];
  logic [DW-1:0] rsp_data_log[$];

  function automatic logic [DW-1:0] heap_min();
    logic [DW-1:0] mn;
    mn = '0;
    foreach (heap_q[j]) begin
      if (j == 0 || heap_q[j] < mn) mn = heap_q[j];
    end
    return mn;
  endfunction

  function automatic void heap_remove_min();
    int idx;
    idx = 0;
    foreach (heap_q[j]) begin
      if (heap_q[j] < heap_q[idx]) idx = j;
    end
    if (heap_q.size() > 0) heap_q.delete(idx);
  endfunction

  function automatic void push_op(int core, bit deq, logic [DW-1:0] data);
    op_deq[core][op_tail[core] % OPQ]  = deq;
    op_data[core][op_tail[core] % OPQ] = data;
    op_tail[core]++;
  endfunction

  function automatic void clear_ops();
    for (int i = 0; i < NUM_REQ; i++) op_head[i] = op_tail[i];
  endfunction

  function automatic bit pending(int core);
    return op_head[core] != op_tail[core];
  endfunction

  function automatic void model_reset();
    m_iss      = 0;
    m_id       = 0;
    m_deq      = 0;
    m_data     = '0;
    m_cool     = 0;
    m_ptr      = 0;
    m_rsp      = 0;
    m_rsp_id   = 0;
    m_rsp_data = '0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending(i)) begin
        req_vld[i]            = 1'b1;
        req_deq[i]            = op_deq[i][op_head[i] % OPQ];
        req_data[i*DW +: DW]  = op_data[i][op_head[i] % OPQ];
      end else begin
        req_vld[i]            = 1'b0;
        req_deq[i]            = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
    q_count    = HD'(heap_q.size());
    q_out_data = heap_min();
  endtask

  // One clock: compare DUT outputs with the model at the negedge, advance
  // model, queue and cores at the posedge, then drive new inputs.
  task automatic run_cycle();
    logic [NUM_REQ-1:0] e_ack;
    logic [1:0]         e_strb;
    logic [DW-1:0]      e_inp;
    logic [1:0]         e_flags;
    bit                 e_rsp;
    bit                 found;
    int                 c;
    e_ack  = '0;
    e_strb = 2'b00;
    e_inp  = '0;
    if (!rst && m_iss) begin
      e_ack[m_id] = 1'b1;
      e_strb      = m_deq ? 2'b01 : 2'b10;
      if (!m_deq) e_inp = m_data;
    end
    e_flags = {heap_q.size() == CAP, heap_q.size() == 0};
    e_rsp   = !rst && m_rsp;

    checks++;
    if (req_ack !== e_ack) begin
      failures++;
      $display("FAIL model_ack cyc=%0d got=%b exp=%b", cyc, req_ack, e_ack);
    end
    checks++;
    if ({q_enq, q_deq} !== e_strb) begin
      failures++;
      $display("FAIL model_strobe cyc=%0d got enq/deq=%b exp=%b", cyc, {q_enq, q_deq}, e_strb);
    end
    checks++;
    if (q_inp_data !== e_inp) begin
      failures++;
      $display("FAIL model_inp cyc=%0d got=%h exp=%h", cyc, q_inp_data, e_inp);
    end
    checks++;
    if ({full, empty} !== e_flags) begin
      failures++;
      $display("FAIL model_flags cyc=%0d got full/empty=%b exp=%b", cyc, {full, empty}, e_flags);
    end
    checks++;
    if (rsp_vld !== e_rsp) begin
      failures++;
      $display("FAIL model_rsp_vld cyc=%0d got=%b exp=%b", cyc, rsp_vld, e_rsp);
    end
    if (e_rsp) begin
      checks++;
      if ({rsp_id, rsp_data} !== {IDW'(m_rsp_id), m_rsp_data}) begin
        failures++;
        $display("FAIL model_rsp cyc=%0d got id=%0d data=%h exp id=%0d data=%h",
                 cyc, rsp_id, rsp_data, m_rsp_id, m_rsp_data);
      end
    end

    if (req_ack !== '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (req_ack[i] === 1'b1) c = i;
      ack_id_log.push_back(c);
      ack_cyc_log.push_back(cyc);
      ack_deq_log.push_back(q_deq);
      ack_inp_log.push_back(q_inp_data);
    end
    if (rsp_vld === 1'b1) begin
      rsp_id_log.push_back(int'(rsp_id));
      rsp_cyc_log.push_back(cyc);
      rsp_data_log.push_back(rsp_data);
    end

    @(posedge CLK);
    cyc++;
    if (rst) begin
      model_reset();
    end else if (m_iss) begin
      m_rsp = m_deq;
      if (m_deq) begin
        m_rsp_id   = m_id;
        m_rsp_data = heap_min();
        heap_remove_min();
      end else begin
        heap_q.push_back(m_data);
      end
      m_ptr  = (m_id + 1) % NUM_REQ;
      m_cool = ISSUE_GAP;
      m_iss  = 0;
      if (pending(m_id)) op_head[m_id]++;
    end else begin
      m_rsp = 0;
      if (m_cool > 0) begin
        m_cool--;
      end else begin
        found = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (!found && pending(c)) begin
            if (op_deq[c][op_head[c] % OPQ] ? (heap_q.size() > 0) : (heap_q.size() < CAP)) begin
              found  = 1;
              m_iss  = 1;
              m_id   = c;
              m_deq  = op_deq[c][op_head[c] % OPQ];
              m_data = op_data[c][op_head[c] % OPQ];
            end
          end
        end
      end
    end

    if (rand_mode) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pending(i) && $urandom_range(0, 2) == 0) begin
          push_op(i, $urandom_range(0, 99) < rand_deq_pct, DW'($urandom));
        end
      end
    end
    #1;
    drive_inputs();
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_iss || m_cool != 0 || m_rsp) && n < 50) begin
      run_cycle();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL wait_idle timeout got cycles=%0d required<50", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) run_cycle();
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    clear_ops();
    heap_q.delete();
    model_reset();
    drive_inputs();
    repeat (2) @(negedge CLK);
    checks++;
    if ({req_ack, q_enq, q_deq, q_inp_data, rsp_vld} !== '0) begin
      failures++;
      $display("FAIL reset_strobes got ack=%b enq=%b deq=%b inp=%h rsp_vld=%b required all 0",
               req_ack, q_enq, q_deq, q_inp_data, rsp_vld);
    end
    checks++;
    if ({rsp_id, rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_rsp got id=%0d data=%h required 0", rsp_id, rsp_data);
    end
    checks++;
    if ({full, empty} !== 2'b01) begin
      failures++;
      $display("FAIL reset_flags got full/empty=%b required 01", {full, empty});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_enq();
    int am, rm, t0;
    am = ack_id_log.size();
    rm = rsp_id_log.size();
    push_op(0, 0, 16'h0040);
    drive_inputs();
    t0 = cyc;
    repeat (6) run_cycle();
    checks++;
    if (ack_id_log.size() != am + 1) begin
      failures++;
      $display("FAIL single_enq_count got=%0d required=1", ack_id_log.size() - am);
    end else begin
      checks++;
      if (ack_id_log[am] != 0 || ack_cyc_log[am] != t0 + 1 || ack_deq_log[am] != 0 ||
          ack_inp_log[am] !== 16'h0040) begin
        failures++;
        $display("FAIL single_enq got id=%0d cyc=%0d deq=%0d inp=%h required id=0 cyc=%0d deq=0 inp=0040",
                 ack_id_log[am], ack_cyc_log[am], ack_deq_log[am], ack_inp_log[am], t0 + 1);
      end
    end
    checks++;
    if (rsp_id_log.size() != rm) begin
      failures++;
      $display("FAIL single_enq_norsp got rsp pulses=%0d required=0", rsp_id_log.size() - rm);
    end
    wait_idle();
  endtask

  task automatic test_all_enq();
    int am, t0;
    do_reset();
    heap_q.delete();
    drive_inputs();
    am = ack_id_log.size();
    for (int i = 0; i < NUM_REQ; i++) push_op(i, 0, DW'(16 * (i + 1)));
    drive_inputs();
    t0 = cyc;
    repeat (16) run_cycle();
    checks++;
    if (ack_id_log.size() != am + 4) begin
      failures++;
      $display("FAIL all_enq_count got=%0d required=4", ack_id_log.size() - am);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_id_log[am+k] != k || ack_cyc_log[am+k] != t0 + 1 + k * (ISSUE_GAP + 2) ||
            ack_inp_log[am+k] !== DW'(16 * (k + 1))) begin
          failures++;
          $display("FAIL all_enq_grant%0d got id=%0d cyc=%0d inp=%h required id=%0d cyc=%0d inp=%h",
                   k, ack_id_log[am+k], ack_cyc_log[am+k], ack_inp_log[am+k],
                   k, t0 + 1 + k * (ISSUE_GAP + 2), DW'(16 * (k + 1)));
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_deq_resp();
    int am, rm, t0;
    heap_q.delete();
    heap_q.push_back(16'h0009);
    heap_q.push_back(16'h0007);
    am = ack_id_log.size();
    rm = rsp_id_log.size();
    push_op(2, 1, 16'h0000);
    drive_inputs();
    t0 = cyc;
    repeat (6) run_cycle();
    checks++;
    if (ack_id_log.size() != am + 1 || ack_id_log[am] != 2 || ack_cyc_log[am] != t0 + 1 ||
        ack_deq_log[am] != 1) begin
      failures++;
      $display("FAIL deq_grant got acks=%0d required one deq grant to core 2 at cyc %0d",
               ack_id_log.size() - am, t0 + 1);
    end
    checks++;
    if (rsp_id_log.size() != rm + 1) begin
      failures++;
      $display("FAIL deq_rsp_count got=%0d required=1", rsp_id_log.size() - rm);
    end else begin
      checks++;
      if (rsp_id_log[rm] != 2 || rsp_data_log[rm] !== 16'h0007 || rsp_cyc_log[rm] != t0 + 2) begin
        failures++;
        $display("FAIL deq_rsp got id=%0d data=%h cyc=%0d required id=2 data=0007 cyc=%0d",
                 rsp_id_log[rm], rsp_data_log[rm], rsp_cyc_log[rm], t0 + 2);
      end
    end
    wait_idle();
  endtask

  task automatic test_full_mixed();
    int am, rm;
    heap_q.delete();
    for (int j = 0; j < CAP; j++) heap_q.push_back(DW'(16'h0100 + j));
    am = ack_id_log.size();
    rm = rsp_id_log.size();
    push_op(1, 0, 16'h0005);
    push_op(3, 1, 16'h0000);
    drive_inputs();
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL full_flag got=%b required=1", full);
    end
    repeat (16) run_cycle();
    checks++;
    if (ack_id_log.size() != am + 2) begin
      failures++;
      $display("FAIL full_count got=%0d required=2", ack_id_log.size() - am);
    end else begin
      checks++;
      if (ack_id_log[am] != 3 || ack_id_log[am+1] != 1 ||
          ack_cyc_log[am+1] - ack_cyc_log[am] != ISSUE_GAP + 2) begin
        failures++;
        $display("FAIL full_order got ids=%0d,%0d gap=%0d required 3,1 gap=%0d",
                 ack_id_log[am], ack_id_log[am+1], ack_cyc_log[am+1] - ack_cyc_log[am], ISSUE_GAP + 2);
      end
    end
    checks++;
    if (rsp_id_log.size() != rm + 1 || rsp_data_log[rm] !== 16'h0100) begin
      failures++;
      $display("FAIL full_rsp got pulses=%0d required one with data=0100", rsp_id_log.size() - rm);
    end
    wait_idle();
  endtask

  task automatic test_empty_deq();
    int am;
`ifdef PRIO_Q_SCHED_STATS_EN
    logic [31:0] s0;
`endif
    heap_q.delete();
    drive_inputs();
    run_cycle();
    am = ack_id_log.size();
    push_op(0, 1, 16'h0000);
    push_op(2, 1, 16'h0000);
    drive_inputs();
`ifdef PRIO_Q_SCHED_STATS_EN
    s0 = stat_stall;
`endif
    repeat (10) run_cycle();
    checks++;
    if (ack_id_log.size() != am || empty !== 1'b1 || q_enq !== 1'b0 || q_deq !== 1'b0) begin
      failures++;
      $display("FAIL empty_hold got acks=%0d empty=%b enq=%b deq=%b required 0,1,0,0",
               ack_id_log.size() - am, empty, q_enq, q_deq);
    end
`ifdef PRIO_Q_SCHED_STATS_EN
    checks++;
    if (stat_stall - s0 != 32'd10) begin
      failures++;
      $display("FAIL stat_stall got delta=%0d required=10", stat_stall - s0);
    end
`endif
    clear_ops();
    drive_inputs();
    run_cycle();
  endtask

  task automatic test_reset_mid_issue();
    int n, am, rm, t0;
    heap_q.delete();
    heap_q.push_back(16'h0003);
    heap_q.push_back(16'h0004);
    push_op(2, 1, 16'h0000);
    drive_inputs();
    n = 0;
    while (!m_iss && n < 20) begin
      run_cycle();
      n++;
    end
    checks++;
    if (!m_iss || q_deq !== 1'b1 || req_ack !== 4'b0100) begin
      failures++;
      $display("FAIL rst_pre got deq=%b ack=%b required deq=1 ack=0100", q_deq, req_ack);
    end
    rm = rsp_id_log.size();
    rst = 1'b1;
    #1;
    checks++;
    if (q_deq !== 1'b0 || q_enq !== 1'b0 || req_ack !== '0) begin
      failures++;
      $display("FAIL rst_drop got enq=%b deq=%b ack=%b required 0", q_enq, q_deq, req_ack);
    end
    clear_ops();
    push_op(3, 1, 16'h0000);
    push_op(1, 1, 16'h0000);
    drive_inputs();
    @(negedge CLK);
    repeat (3) run_cycle();
    checks++;
    if (rsp_id_log.size() != rm) begin
      failures++;
      $display("FAIL rst_no_rsp got pulses=%0d required=0", rsp_id_log.size() - rm);
    end
    rst = 1'b0;
    am = ack_id_log.size();
    t0 = cyc;
    repeat (12) run_cycle();
    checks++;
    if (ack_id_log.size() != am + 2) begin
      failures++;
      $display("FAIL rst_after_count got=%0d required=2", ack_id_log.size() - am);
    end else begin
      checks++;
      if (ack_id_log[am] != 1 || ack_cyc_log[am] != t0 + 1 || ack_id_log[am+1] != 3) begin
        failures++;
        $display("FAIL rst_rr_ptr got ids=%0d,%0d first cyc=%0d required 1,3 first cyc=%0d",
                 ack_id_log[am], ack_id_log[am+1], ack_cyc_log[am], t0 + 1);
      end
    end
    checks++;
    if (rsp_id_log.size() != rm + 2 || rsp_data_log[rm] !== 16'h0003) begin
      failures++;
      $display("FAIL rst_after_rsp got pulses=%0d required 2, first data=0003", rsp_id_log.size() - rm);
    end
    wait_idle();
  endtask

  task automatic test_random();
    int am;
    am = ack_id_log.size();
    rand_mode    = 1;
    rand_deq_pct = 25;
    repeat (400) run_cycle();
    rand_deq_pct = 75;
    repeat (400) run_cycle();
    rand_mode = 0;
    wait_idle();
    clear_ops();
    drive_inputs();
    run_cycle();
    checks++;
    if (ack_id_log.size() - am < 50) begin
      failures++;
      $display("FAIL random_activity got grants=%0d required>=50", ack_id_log.size() - am);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_head[i] = 0;
      op_tail[i] = 0;
    end
    req_vld    = '0;
    req_deq    = '0;
    req_data   = '0;
    q_count    = '0;
    q_out_data = '0;
    test_reset();
    test_single_enq();
    test_all_enq();
    test_deq_resp();
    test_full_mixed();
    test_empty_deq();
    test_reset_mid_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prio_q_sched.md
Name: prio_q_sched

Overview:
- Scheduler/arbiter that shares one event priority queue (min-heap, DW-bit keys, capacity 2^HD-1) among NUM_REQ simulation cores.
- Arbitrates per-core enqueue/dequeue requests round-robin, drives the queue's enq/deq/inp_data strobes, returns dequeued minimum keys to the winning core.
- Enforces full/empty guarding and an idle gap after every issue so heap propagation settles before the next operation.

Parameters:
- NUM_REQ, 4, number of requesting cores (2..8)
- DW, 16, key/data width, matches queue data bus
- HD, 5, heap depth; capacity CAP = 2^HD-1 = 31
- ISSUE_GAP, 2, idle cycles after each issue (legal 1..15)
- IDW, $clog2(NUM_REQ), requester id width (derived)

Ports:
- CLK  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_vld  in  NUM_REQ  per-core request pending
- req_deq  in  NUM_REQ  per-core op: 1=dequeue, 0=enqueue
- req_data  in  NUM_REQ*DW  per-core enqueue key, core i at [i*DW +: DW]
- req_ack  out  NUM_REQ  one-hot, one-cycle grant pulse
- rsp_vld  out  1  dequeued key valid (one-cycle pulse)
- rsp_id  out  IDW  core receiving rsp_data
- rsp_data  out  DW  dequeued minimum key
- q_enq  out  1  queue enqueue strobe
- q_deq  out  1  queue dequeue strobe
- q_inp_data  out  DW  key presented to queue
- q_out_data  in  DW  queue root (current minimum)
- q_count  in  HD  queue element count
- full  out  1  q_count == CAP (combinational)
- empty  out  1  q_count == 0 (combinational)

Behaviour:
- Reset: state IDLE, rr_ptr=0, gap counter 0; req_ack, rsp_vld, rsp_id, rsp_data, q_enq, q_deq, q_inp_data all 0. Reset mid-operation aborts any pending strobe/response; nothing issued afterwards.
- Eligibility: core i eligible iff req_vld[i] && (req_deq[i] ? !empty : !full). Ineligible requests wait, never dropped.
- FSM states: IDLE, ISSUE, GAP.
- IDLE: if any core eligible, pick first eligible at or after rr_ptr (wrapping mod NUM_REQ); register winner id, op, data; -> ISSUE. Else stay.
- ISSUE (1 cycle): q_enq or q_deq high exactly this cycle (never both); q_inp_data = captured key for enqueue, 0 for dequeue; req_ack[winner]=1; rr_ptr <= (winner+1) mod NUM_REQ; -> GAP with counter=ISSUE_GAP.
- Dequeue response: on the ISSUE-cycle edge, rsp_data <= q_out_data (pre-dequeue root), rsp_id <= winner; rsp_vld=1 in the following cycle only.
- GAP: decrement counter; at 1 -> IDLE. No arbitration in ISSUE/GAP.
- Latency: request eligible in IDLE cycle T -> q_enq/q_deq and req_ack at T+1 -> rsp_vld at T+2. Issue rate max one op per ISSUE_GAP+2 cycles.
- Requester holds req_vld/req_deq/req_data stable until ack; deasserts or presents a new request the cycle after ack. Changes before ack are sampled at the next IDLE arbitration.
- full/empty evaluated on q_count only in IDLE; GAP guarantees q_count settled.
- Simultaneous: full with mixed ops -> only dequeuers eligible; empty -> only enqueuers eligible; all pending ineligible -> stay IDLE.

Optional Feature:
- Macro PRIO_Q_SCHED_STATS_EN.
- Defined: extra outputs stat_enq (32), stat_deq (32), stat_stall (32), stat_hwm (HD). Counters increment on q_enq, q_deq, and each IDLE cycle with some req_vld set but no core eligible; stat_hwm = max q_count seen. Saturating; cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, core0 enqueue 0x0040 -> ack[0] and q_enq with q_inp_data=0x0040 one cycle after request; no rsp_vld.
- All 4 cores enqueue together (keys 0x10,0x20,0x30,0x40), rr_ptr=0 -> grants 0,1,2,3 in order, issues spaced ISSUE_GAP+2=4 cycles.
- q_count=2, q_out_data=0x0007, core2 dequeue -> q_deq at T+1, rsp_vld at T+2 with rsp_id=2, rsp_data=0x0007.
- q_count=31, core1 enqueue + core3 dequeue -> core3 served first, core1 served next IDLE after q_count=30.
- q_count=0, only dequeue requests -> no strobes, no acks, empty=1; stat_stall increments each cycle (stats build).
- rst asserted in ISSUE -> q_enq/req_ack drop immediately, rsp_vld never pulses, rr_ptr=0 after release.
